manchester_serial_rx: RTL and testbench

Receive-side counterpart of the Manchester serial transmitter. It consumes the half-bit stream produced by the TX shift stage, one half-bit per clock, and hunts for a sync byte to find byte alignment. It then decodes Manchester pairs into bytes and delivers them on an AXI4-Stream master through a small FIFO. It sits directly downstream of the TX serial output, either in loopback or after the link's sampling/data-recovery stage.

---
 rtl/manchester_serial_rx.sv | 187 ++++++++++++++++++
 tb/tb_manchester_serial_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_serial_rx.sv
// Manchester half-bit receiver: hunts for the encoded sync, decodes pairs MSB first, queues bytes onto AXI4-Stream.
// Optional saturating statistics counters are built when MANCHESTER_RX_STATS_EN is defined.
module manchester_serial_rx #(
    parameter logic [7:0] SYNC_BYTE  = 8'hD5,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_in,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        lock,
    output logic        code_err,
    output logic        overflow,
    output logic [15:0] stat_bytes,
    output logic [15:0] stat_errs,
    output logic [15:0] stat_ovf
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    function automatic logic [15:0] enc(input logic [7:0] b);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) e[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        return e;
    endfunction

    localparam logic [15:0] ENC_SYNC = enc(SYNC_BYTE);

    typedef enum logic {HUNT, DATA} state_t;

    state_t      state_q, state_d;
    logic [14:0] win_q;  // the oldest half-bit only matters for the compare, so it is never stored
    logic [15:0] win_d;
    logic [3:0]  hcnt_q, hcnt_d;
    logic [6:0]  acc_q, acc_d;
    logic        dec_push_q, dec_push_d;
    logic        dec_err_q, dec_err_d;
    logic [7:0]  dec_byte_q, dec_byte_d;
    logic        code_err_q, code_err_d;
    logic        overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    pair;
    logic          pair_ok;
    logic          fifo_full, fifo_push, fifo_pop;

    // Decode runs one cycle behind the sample; its verdict lands on the following edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win_d      = {win_q, serial_in};
        pair       = win_d[1:0];
        pair_ok    = pair[1] ^ pair[0];
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        acc_d      = acc_q;
        dec_push_d = 1'b0;
        dec_err_d  = 1'b0;
        dec_byte_d = dec_byte_q;
        code_err_d = dec_err_q;

        case (state_q)
            HUNT: begin
                if (win_d == ENC_SYNC) begin
                    state_d = DATA;
                    hcnt_d  = 4'd0;
                    acc_d   = 7'd0;
                end
            end
            DATA: begin
                hcnt_d = hcnt_q + 4'd1;
                if (hcnt_q[0]) begin
                    if (pair_ok) begin
                        acc_d = {acc_q[5:0], pair[1]};
                        if (hcnt_q == 4'd15) begin
                            dec_push_d = 1'b1;
                            dec_byte_d = {acc_q, pair[1]};
                        end
                    end else begin
                        dec_err_d = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (dec_err_q) begin
            state_d = HUNT;
            hcnt_d  = 4'd0;
            acc_d   = 7'd0;
        end
    end

    always_comb begin
        m_axis_tvalid = (count_q != '0);
        m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : 8'h00;
        fifo_pop      = m_axis_tvalid & m_axis_tready;
        fifo_full     = (count_q == DEPTH_C);
        fifo_push     = dec_push_q & (~fifo_full | fifo_pop);
        overflow_d    = dec_push_q & fifo_full & ~fifo_pop;
        wr_ptr_d      = fifo_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = fifo_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            win_q      <= '0;
            hcnt_q     <= '0;
            acc_q      <= '0;
            dec_push_q <= 1'b0;
            dec_err_q  <= 1'b0;
            dec_byte_q <= '0;
            code_err_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d[14:0];
            hcnt_q     <= hcnt_d;
            acc_q      <= acc_d;
            dec_push_q <= dec_push_d;
            dec_err_q  <= dec_err_d;
            dec_byte_q <= dec_byte_d;
            code_err_q <= code_err_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage is not reset; occupancy gates tdata, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (fifo_push) mem_q[wr_ptr_q] <= dec_byte_q;
    end

    assign lock     = (state_q == DATA);
    assign code_err = code_err_q;
    assign overflow = overflow_q;

`ifdef MANCHESTER_RX_STATS_EN
    logic [15:0] stat_bytes_q, stat_bytes_d;
    logic [15:0] stat_errs_q,  stat_errs_d;
    logic [15:0] stat_ovf_q,   stat_ovf_d;

    always_comb begin
        stat_bytes_d = stat_bytes_q;
        stat_errs_d  = stat_errs_q;
        stat_ovf_d   = stat_ovf_q;
        if (fifo_push  && stat_bytes_q != 16'hFFFF) stat_bytes_d = stat_bytes_q + 16'd1;
        if (code_err_d && stat_errs_q  != 16'hFFFF) stat_errs_d  = stat_errs_q  + 16'd1;
        if (overflow_d && stat_ovf_q   != 16'hFFFF) stat_ovf_d   = stat_ovf_q   + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bytes_q <= '0;
            stat_errs_q  <= '0;
            stat_ovf_q   <= '0;
        end else begin
            stat_bytes_q <= stat_bytes_d;
            stat_errs_q  <= stat_errs_d;
            stat_ovf_q   <= stat_ovf_d;
        end
    end

    assign stat_bytes = stat_bytes_q;
    assign stat_errs  = stat_errs_q;
    assign stat_ovf   = stat_ovf_q;
`else
    assign stat_bytes = 16'h0000;
    assign stat_errs  = 16'h0000;
    assign stat_ovf   = 16'h0000;
`endif

endmodule

// File: tb/tb_manchester_serial_rx.sv
// Directed and randomized bench for manchester_serial_rx against a transaction-level byte/FIFO model.
module tb_manchester_serial_rx;
    localparam int DEPTH = 4;
`ifdef MANCHESTER_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        lock, code_err, overflow;
    logic [15:0] stat_bytes, stat_errs, stat_ovf;

    manchester_serial_rx #(.SYNC_BYTE(8'hD5), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .lock         (lock),
        .code_err     (code_err),
        .overflow     (overflow),
        .stat_bytes   (stat_bytes),
        .stat_errs    (stat_errs),
        .stat_ovf     (stat_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int m_bytes = 0, m_errs = 0, m_ovf = 0;
    int err_seen = 0, ovf_seen = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit 1 -> "10", bit 0 -> "01", most significant bit transmitted first.
    function automatic logic [15:0] enc_ref(input logic [7:0] b);
        logic [15:0] e;
        e = '0;
        for (int i = 7; i >= 0; i--) e = {e[13:0], b[i], ~b[i]};
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL pop_unexpected: observed=%0h expected=none", m_axis_tdata);
            end
            if (exp_q.size() != 0) check("pop_data", 16'(m_axis_tdata), 16'(exp_q.pop_front()));
        end
        if (code_err) err_seen++;
        if (overflow) ovf_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic send_bits(input logic [15:0] e, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(e[i]);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
            m_bytes++;
        end else begin
            m_ovf++;
        end
    endtask

    task automatic send_sync();
        logic [15:0] e;
        e = enc_ref(8'hD5);
        send_bits(e, 15, 1);
        check("lock_before_sync_end", 16'(lock), 16'd0);
        step(e[0]);
        check("lock_at_sync_end", 16'(lock), 16'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(enc_ref(b), 15, 0);
        model_push(b);
    endtask

    // Drops lock with a deliberate "00" pair; first_done means its first half-bit was already sent.
    task automatic unlock(input bit first_done);
        if (!first_done) step(1'b0);
        step(1'b0);
        check("unlock_lock_held", 16'(lock), 16'd1);
        check("unlock_no_err_yet", 16'(code_err), 16'd0);
        step(1'b0);
        check("unlock_err_pulse", 16'(code_err), 16'd1);
        check("unlock_lock_drop", 16'(lock), 16'd0);
        m_errs++;
        step(1'b0);
        check("unlock_err_single", 16'(code_err), 16'd0);
        idle(16);
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            step(1'b0);
        end
        check("drain_empty", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic check_stats();
        check("stat_bytes", stat_bytes, STATS ? 16'(m_bytes) : 16'h0000);
        check("stat_errs",  stat_errs,  STATS ? 16'(m_errs)  : 16'h0000);
        check("stat_ovf",   stat_ovf,   STATS ? 16'(m_ovf)   : 16'h0000);
    endtask

    initial begin
        logic [15:0] e;
        logic [7:0]  b;
        int          n, e0, o0;

        rst           = 1'b1;
        serial_in     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) begin
            serial_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("rst_tdata", 16'(m_axis_tdata), 16'd0);
        check("rst_lock", 16'(lock), 16'd0);
        check("rst_code_err", 16'(code_err), 16'd0);
        check("rst_overflow", 16'(overflow), 16'd0);
        check_stats();
        rst = 1'b0;
        idle(20);
        check("idle_lock", 16'(lock), 16'd0);
        check("idle_tvalid", 16'(m_axis_tvalid), 16'd0);

        // Sync, then two bytes with latency checks.
        send_sync();
        e = enc_ref(8'hA5);
        send_bits(e, 15, 0);
        model_push(8'hA5);
        check("a5_not_early", 16'(m_axis_tvalid), 16'd0);
        e = enc_ref(8'h3C);
        step(e[15]);
        check("a5_tvalid", 16'(m_axis_tvalid), 16'd1);
        check("a5_tdata", 16'(m_axis_tdata), 16'hA5);
        send_bits(e, 14, 0);
        model_push(8'h3C);
        check("3c_not_early", 16'(m_axis_tvalid), 16'd0);
        step(1'b0);
        check("3c_tvalid", 16'(m_axis_tvalid), 16'd1);
        check("3c_tdata", 16'(m_axis_tdata), 16'h3C);
        unlock(1'b1);
        drain();

        // Invalid third pair inside 0x12.
        send_sync();
        e0 = err_seen;
        e = enc_ref(8'h12);
        e[11:10] = 2'b11;
        send_bits(e, 15, 10);
        check("bad_pair_lock_held", 16'(lock), 16'd1);
        check("bad_pair_not_early", 16'(code_err), 16'd0);
        step(e[9]);
        check("bad_pair_err", 16'(code_err), 16'd1);
        check("bad_pair_unlock", 16'(lock), 16'd0);
        m_errs++;
        send_bits(e, 8, 0);
        check("bad_pair_one_pulse", 16'(err_seen - e0), 16'd1);
        idle(16);
        send_sync();
        send_byte(8'h7E);
        unlock(1'b0);
        drain();
        check_stats();

        // Stalled downstream: six bytes into a four-entry FIFO.
        m_axis_tready = 1'b0;
        o0 = ovf_seen;
        send_sync();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        send_bits(enc_ref(8'h05), 15, 0);
        model_push(8'h05);
        check("ovf_not_early", 16'(overflow), 16'd0);
        e = enc_ref(8'h06);
        step(e[15]);
        check("ovf_pulse", 16'(overflow), 16'd1);
        check("ovf_lock_held", 16'(lock), 16'd1);
        send_bits(e, 14, 0);
        model_push(8'h06);
        step(1'b0);
        unlock(1'b1);
        check("ovf_pulse_count", 16'(ovf_seen - o0), 16'd2);
        check("stall_tvalid", 16'(m_axis_tvalid), 16'd1);
        check("stall_tdata", 16'(m_axis_tdata), 16'h01);
        check_stats();
        m_axis_tready = 1'b1;
        drain();

        // Random frames.
        repeat (4) begin
            send_sync();
            n = $urandom_range(1, 4);
            repeat (n) begin
                b = 8'($urandom);
                send_byte(b);
                check("rand_lock", 16'(lock), 16'd1);
            end
            unlock(1'b0);
            drain();
        end

        // Sync value as payload is forwarded.
        send_sync();
        send_byte(8'hD5);
        check("d5_lock_held", 16'(lock), 16'd1);
        unlock(1'b0);
        drain();

        // Reset in the middle of a byte.
        send_sync();
        send_bits(enc_ref(8'($urandom)), 15, 11);
        rst       = 1'b1;
        serial_in = 1'($urandom);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_bytes = 0;
        m_errs  = 0;
        m_ovf   = 0;
        check("midrst_lock", 16'(lock), 16'd0);
        check("midrst_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("midrst_code_err", 16'(code_err), 16'd0);
        check_stats();
        idle(20);
        check("midrst_no_partial", 16'(m_axis_tvalid), 16'd0);
        send_sync();
        send_byte(8'h99);
        unlock(1'b0);
        drain();
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
